// File: rtl/chroma_upsample.sv
// chroma_upsample: 4:2:0 to 4:4:4 by nearest-neighbour chroma replication.
// Even-line chroma is stored in a half-line buffer and replayed on the following odd line.
module chroma_upsample #(
    parameter int SENSOR_X_SIZE = 720,
    parameter int SENSOR_Y_SIZE = 720,
    parameter int DW = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic [DW-1:0] yuv_in [2:0],
    input  logic [2:0] yuv_in_valid,
    output logic yuv_in_hold,
    input  logic frame_valid_in,
    input  logic line_valid_in,
    output logic [DW-1:0] yuv_out [2:0],
    output logic yuv_out_valid,
    input  logic yuv_out_hold,
    output logic eof_out,
    output logic [$clog2(SENSOR_X_SIZE)-1:0] yuv_out_pixel_count,
    output logic [$clog2(SENSOR_Y_SIZE)-1:0] yuv_out_line_count
);
    localparam int XW = $clog2(SENSOR_X_SIZE);
    localparam int YW = $clog2(SENSOR_Y_SIZE);
    localparam int DEPTH = SENSOR_X_SIZE / 2;

    typedef enum logic [1:0] {IDLE, EMIT_EVEN, EMIT_ODD} state_t;
    state_t state, state_nxt;

    logic en, acc, eol, eof, odd_line, odd_px, pair_acc, flush, rd_en, wr_en, rd_pend;
    logic lv_q, fv_q, eof_d;
    logic [XW-1:0] pixel_count;
    logic [YW-1:0] line_count;
    logic [DW-1:0] y0_reg, y1_reg, u_reg, v_reg;
    logic [2*DW-1:0] mem [DEPTH];
    logic [2*DW-1:0] rd_data, cur_uv, chroma;

    assign en = !yuv_out_hold;
    assign yuv_in_hold = yuv_out_hold;
    assign acc = line_valid_in & yuv_in_valid[0] & en;
    assign eol = lv_q & !line_valid_in;
    assign eof = fv_q & !frame_valid_in;
    assign odd_line = line_count[0];
    assign odd_px = pixel_count[0];
    assign pair_acc = acc & odd_px;
    assign flush = en & eol & odd_px;
    assign rd_en = acc & !odd_px & odd_line;
    assign wr_en = en & !odd_line & (pair_acc | flush);
    // a read issued last un-held cycle has not yet landed in u_reg/v_reg
    assign cur_uv = rd_pend ? rd_data : {v_reg, u_reg};
    assign chroma = (!odd_line && pair_acc && yuv_in_valid[2]) ? {yuv_in[2], u_reg} : cur_uv;

    always_ff @(posedge clk) begin
        if (wr_en) mem[pixel_count[XW-1:1]] <= chroma;
        if (rd_en) rd_data <= mem[pixel_count[XW-1:1]];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lv_q <= 1'b0;
            fv_q <= 1'b0;
            eof_d <= 1'b0;
            rd_pend <= 1'b0;
            pixel_count <= '0;
            line_count <= '0;
            y0_reg <= '0;
            y1_reg <= '0;
            u_reg <= '0;
            v_reg <= '0;
        end else if (en) begin
            lv_q <= line_valid_in;
            fv_q <= frame_valid_in;
            eof_d <= eof;
            rd_pend <= rd_en;
            pixel_count <= (eof || eol) ? '0 : pixel_count + XW'(acc);
            line_count <= eof ? '0 : line_count + YW'(eol);
            if (rd_pend) {v_reg, u_reg} <= rd_data;
            if (acc && !odd_px) y0_reg <= yuv_in[0];
            if (acc && !odd_px && !odd_line && yuv_in_valid[1]) u_reg <= yuv_in[1];
            if (pair_acc && !odd_line && yuv_in_valid[2]) v_reg <= yuv_in[2];
            if (pair_acc) y1_reg <= yuv_in[0];
        end
    end

    always_comb begin
        state_nxt = pair_acc ? EMIT_EVEN : (state == EMIT_EVEN) ? EMIT_ODD : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            yuv_out <= '{default: '0};
            yuv_out_valid <= 1'b0;
            eof_out <= 1'b0;
            yuv_out_pixel_count <= '0;
            yuv_out_line_count <= '0;
        end else if (en) begin
            state <= state_nxt;
            yuv_out_valid <= pair_acc | flush | (state == EMIT_EVEN);
            eof_out <= eof_d;
            if (pair_acc || flush) begin
                yuv_out[0] <= y0_reg;
                {yuv_out[2], yuv_out[1]} <= chroma;
                yuv_out_pixel_count <= pixel_count - XW'(1);
                yuv_out_line_count <= line_count;
            end else if (state == EMIT_EVEN) begin
                yuv_out[0] <= y1_reg;
                yuv_out_pixel_count <= yuv_out_pixel_count + XW'(1);
            end
        end
    end
endmodule

// File: tb/tb_chroma_upsample.sv
// tb_chroma_upsample: randomized frames scored against a raster-order 4:2:0 -> 4:4:4 reference.
module tb_chroma_upsample;
    logic clk = 0;
    logic resetn = 0;
    logic [7:0] yuv_in [2:0];
    logic [2:0] yuv_in_valid = 0;
    logic yuv_in_hold;
    logic frame_valid_in = 0;
    logic line_valid_in = 0;
    logic [7:0] yuv_out [2:0];
    logic yuv_out_valid;
    logic yuv_out_hold = 0;
    logic eof_out;
    logic [9:0] yuv_out_pixel_count;
    logic [9:0] yuv_out_line_count;

    chroma_upsample dut (
        .clk(clk), .resetn(resetn), .yuv_in(yuv_in), .yuv_in_valid(yuv_in_valid),
        .yuv_in_hold(yuv_in_hold), .frame_valid_in(frame_valid_in), .line_valid_in(line_valid_in),
        .yuv_out(yuv_out), .yuv_out_valid(yuv_out_valid), .yuv_out_hold(yuv_out_hold),
        .eof_out(eof_out), .yuv_out_pixel_count(yuv_out_pixel_count),
        .yuv_out_line_count(yuv_out_line_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y, u, v;
        logic [9:0] x, l;
        logic lat;
    } exp_t;

    exp_t exp_q[$];
    int acc_q[$];
    int vectors = 0, miscompares = 0, eof_cnt = 0, ucnt = 0, hold_pct = 0;
    bit mon_ignore = 0;
    logic [7:0] fy [0:5][0:719];
    logic [7:0] fu [0:5][0:719];
    logic [7:0] fv [0:5][0:719];
    bit fuo [0:5][0:719];
    bit fvo [0:5][0:719];
    logic [7:0] u_last = 0, v_last = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return {yuv_out[0], yuv_out[1], yuv_out[2], yuv_out_valid, eof_out,
                yuv_out_pixel_count, yuv_out_line_count};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2 yuv_out_hold = ($urandom_range(99) < hold_pct);
        end
    end

    // monitor / scoreboard
    initial begin
        bit prev_held = 0;
        logic [63:0] prev_o = 0;
        exp_t e;
        int t;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_held = 0;
                continue;
            end
            if (prev_held) check("hold_stable", outs(), prev_o);
            check("in_hold", yuv_in_hold, yuv_out_hold);
            if (!mon_ignore && line_valid_in && yuv_in_valid[0] && !yuv_out_hold) acc_q.push_back(ucnt);
            if (!mon_ignore && yuv_out_valid && !yuv_out_hold) begin
                check("pixel_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    t = acc_q.size() != 0 ? acc_q.pop_front() : ucnt;
                    check("pixel", {yuv_out[0], yuv_out[1], yuv_out[2], yuv_out_pixel_count,
                                    yuv_out_line_count}, {e.y, e.u, e.v, e.x, e.l});
                    if (e.lat) check("latency", ucnt - t, 2);
                end
            end
            if (eof_out && !yuv_out_hold) begin
                eof_cnt++;
                if (!mon_ignore) check("eof_after_last", exp_q.size(), 0);
            end
            prev_held = yuv_out_hold;
            prev_o = outs();
            if (!yuv_out_hold) ucnt++;
        end
    end

    // reference: each even line's chroma pairs (with keep-last on missing U/V) serve that line and the next
    task automatic push_expected(int w, int h, bit even_lat);
        logic [7:0] cu [0:359];
        logic [7:0] cv [0:359];
        exp_t e;
        for (int l = 0; l < h; l++) begin
            if (l % 2 == 0) begin
                for (int x = 0; x < w; x++) begin
                    if (x % 2 == 0 && fuo[l][x]) u_last = fu[l][x];
                    if (x % 2 == 1 && fvo[l][x]) v_last = fv[l][x];
                    if (x % 2 == 1 || x == w - 1) begin
                        cu[x/2] = u_last;
                        cv[x/2] = v_last;
                    end
                end
            end
            for (int x = 0; x < w; x++) begin
                e.y = fy[l][x];
                e.u = cu[x/2];
                e.v = cv[x/2];
                e.x = 10'(x);
                e.l = 10'(l);
                e.lat = (x % 2 == 1) || (even_lat && x + 1 < w);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step(output bit took);
        @(negedge clk);
        took = !yuv_out_hold;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until_took();
        bit t;
        do step(t); while (!t);
    endtask

    task automatic gen_frame(int w, int h, int drop_pct);
        for (int l = 0; l < h; l++)
            for (int x = 0; x < w; x++) begin
                fy[l][x] = 8'($urandom);
                fu[l][x] = 8'($urandom);
                fv[l][x] = 8'($urandom);
                fuo[l][x] = $urandom_range(99) >= drop_pct;
                fvo[l][x] = $urandom_range(99) >= drop_pct;
            end
    endtask

    task automatic ramp();
        for (int x = 0; x < 4; x++) begin
            fy[0][x] = 8'(10 + x);
            fy[1][x] = 8'(20 + x);
            fu[0][x] = 8'(100 + x);
            fv[0][x] = 8'(100 + x);
            fuo[0][x] = 1;
            fvo[0][x] = 1;
        end
    endtask

    task automatic run_frame(int w, int h, int gap_pct, bit ff_odd, int abort_n);
        bit t;
        int n = 0;
        if (!mon_ignore) push_expected(w, h, gap_pct == 0);
        frame_valid_in = 1;
        idle_until_took();
        for (int l = 0; l < h; l++) begin
            for (int x = 0; x < w; x++) begin
                while ($urandom_range(99) < gap_pct) begin
                    line_valid_in = 1;
                    yuv_in_valid = 0;
                    step(t);
                end
                line_valid_in = 1;
                yuv_in[0] = fy[l][x];
                if (l % 2 == 0) begin
                    yuv_in[1] = fu[l][x];
                    yuv_in[2] = fv[l][x];
                    yuv_in_valid = {x % 2 == 1 && fvo[l][x], x % 2 == 0 && fuo[l][x], 1'b1};
                end else begin
                    yuv_in[1] = ff_odd ? 8'hff : 8'($urandom);
                    yuv_in[2] = ff_odd ? 8'hff : 8'($urandom);
                    yuv_in_valid = 3'b111;
                end
                do step(t); while (!t);
                n++;
                if (n == abort_n) return;
            end
            line_valid_in = 0;
            yuv_in_valid = 0;
            idle_until_took();
            repeat ($urandom_range(0, 2)) step(t);
        end
        frame_valid_in = 0;
    endtask

    task automatic finish_frame(int e0);
        for (int i = 0; i < 300 && eof_cnt == e0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check("eof_count", eof_cnt - e0, 1);
        check("drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        resetn = 0;
        frame_valid_in = 0;
        line_valid_in = 0;
        yuv_in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        acc_q.delete();
        mon_ignore = 0;
        u_last = 0;
        v_last = 0;
        resetn = 1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset", outs(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e0, w, h;
        yuv_in = '{default: '0};
        do_reset();
        // 4x2 ramp; odd line carries 0xFF chroma with valid set
        ramp();
        e0 = eof_cnt;
        run_frame(4, 2, 0, 1, -1);
        finish_frame(e0);
        // missing U at x=2 on line 0
        ramp();
        fuo[0][2] = 0;
        e0 = eof_cnt;
        run_frame(4, 2, 0, 1, -1);
        finish_frame(e0);
        // odd width
        gen_frame(5, 2, 0);
        e0 = eof_cnt;
        run_frame(5, 2, 0, 0, -1);
        finish_frame(e0);
        // random shapes, gaps and dropped chroma
        repeat (8) begin
            w = $urandom_range(1, 40);
            h = $urandom_range(1, 6);
            gen_frame(w, h, 15);
            e0 = eof_cnt;
            run_frame(w, h, 20, 0, -1);
            finish_frame(e0);
        end
        // full-width frame under 30% backpressure
        hold_pct = 30;
        gen_frame(720, 4, 0);
        e0 = eof_cnt;
        run_frame(720, 4, 0, 0, -1);
        finish_frame(e0);
        repeat (3) begin
            w = $urandom_range(1, 30);
            h = $urandom_range(1, 5);
            gen_frame(w, h, 15);
            e0 = eof_cnt;
            run_frame(w, h, 20, 0, -1);
            finish_frame(e0);
        end
        hold_pct = 0;
        @(posedge clk);
        #1;
        // mid-frame reset, then a clean frame
        e0 = eof_cnt;
        ramp();
        mon_ignore = 1;
        run_frame(4, 2, 0, 0, 7);
        do_reset();
        ramp();
        run_frame(4, 2, 0, 1, -1);
        finish_frame(e0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
